// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Framed byte-stream loader feeding the CPU's external
//               instruction and data memory ports, plus a run command that
//               raises cpu_enable.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [31:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [31:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_CNT_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_RUN    = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [7:0] C_TGT_IMEM = 8'h00;
    localparam logic [7:0] C_TGT_DMEM = 8'h01;
    localparam logic [7:0] C_TGT_RUN  = 8'hFF;

    state_t      r_state;
    logic        r_tgt_dmem;     // latched target: 0 = IMEM, 1 = DMEM
    logic [7:0]  r_cnt_lo;
    logic [15:0] r_cnt;
    logic [15:0] r_idx;
    logic [1:0]  r_lane;
    logic [31:0] r_word;

    logic [31:0] r_addr_i;
    logic [31:0] r_wdata_i;
    logic        r_wen_i;
    logic [31:0] r_addr_d;
    logic [31:0] r_wdata_d;
    logic        r_wen_d;
    logic        r_cpu_enable;
    logic        r_busy;
    logic        r_err;

    logic        w_accept;
    logic [15:0] w_cnt_full;
    logic [31:0] w_limit;
    logic [15:0] w_idx_inc;
    logic [31:0] w_word_next;

    // Ready is a pure decode of the state so a stall never costs a cycle
    assign s_ready = (r_state == ST_IDLE)   || (r_state == ST_CNT_LO) ||
                     (r_state == ST_CNT_HI) || (r_state == ST_DATA);

    assign w_accept    = s_valid && s_ready;
    assign w_cnt_full  = {s_data, r_cnt_lo};
    assign w_limit     = r_tgt_dmem ? DMEM_WORDS : IMEM_WORDS;
    assign w_idx_inc   = r_idx + 16'd1;
    // Little-endian assembly: the first byte shifts down to bits [7:0]
    assign w_word_next = {s_data, r_word[31:8]};

    // Frame parser, word assembly and registered memory-port drive
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= ST_IDLE;
            r_tgt_dmem   <= 1'b0;
            r_cnt_lo     <= 8'd0;
            r_cnt        <= 16'd0;
            r_idx        <= 16'd0;
            r_lane       <= 2'd0;
            r_word       <= 32'd0;
            r_addr_i     <= 32'd0;
            r_wdata_i    <= 32'd0;
            r_wen_i      <= 1'b0;
            r_addr_d     <= 32'd0;
            r_wdata_d    <= 32'd0;
            r_wen_d      <= 1'b0;
            r_cpu_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (s_data == C_TGT_IMEM || s_data == C_TGT_DMEM) begin
                            r_tgt_dmem <= (s_data == C_TGT_DMEM);
                            r_state    <= ST_CNT_LO;
                            r_busy     <= 1'b1;
                        end else if (s_data == C_TGT_RUN) begin
                            r_state      <= ST_RUN;
                            r_cpu_enable <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ST_CNT_LO: begin
                    if (w_accept) begin
                        r_cnt_lo <= s_data;
                        r_state  <= ST_CNT_HI;
                    end
                end
                ST_CNT_HI: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_full;
                        if (w_cnt_full == 16'd0) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else if ({16'd0, w_cnt_full} > w_limit) begin
                            r_state <= ST_ERR;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_idx   <= 16'd0;
                            r_lane  <= 2'd0;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_word <= w_word_next;
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            r_state <= ST_WRITE;
                            if (r_tgt_dmem) begin
                                r_wen_d   <= 1'b1;
                                r_addr_d  <= {14'd0, r_idx, 2'b00};
                                r_wdata_d <= w_word_next;
                            end else begin
                                r_wen_i   <= 1'b1;
                                r_addr_i  <= {14'd0, r_idx, 2'b00};
                                r_wdata_i <= w_word_next;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    r_wen_i <= 1'b0;
                    r_wen_d <= 1'b0;
                    r_idx   <= w_idx_inc;
                    if (w_idx_inc == r_cnt) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DATA;
                    end
                end
                ST_RUN: begin
                    r_state <= ST_RUN;
                end
                ST_ERR: begin
                    r_state <= ST_ERR;
                end
                default: begin
                    r_state <= ST_ERR;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign addr_ext    = r_addr_i;
    assign wdata_ext   = r_wdata_i;
    assign wen_ext     = r_wen_i;
    assign ren_ext     = 1'b0;
    assign addr_ext_2  = r_addr_d;
    assign wdata_ext_2 = r_wdata_d;
    assign wen_ext_2   = r_wen_d;
    assign ren_ext_2   = 1'b0;
    assign cpu_enable  = r_cpu_enable;
    assign busy        = r_busy;
    assign err         = r_err;

endmodule
`default_nettype wire
